adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Round-robin controller that shares one 4-bit ripple-carry adder between NREQ requesters.
- Each requester presents A, B and Cin with a request. The controller grants one requester, latches its operands and waits ADD_LAT cycles for the ripple chain to settle. It then returns a 5-bit sum tagged with the requester id, plus a BCD-range error flag.
- Sits between switch/keypad front-end logic and the HEX display path on the DE2 board.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand width in bits.
- ADD_LAT, 1, settle cycles allowed for the adder before sampling (1..7).
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- req  in  NREQ  per-requester request level.
- op_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- op_b  in  NREQ*W  operand B, same packing.
- cin  in  NREQ  carry-in per requester.
- gnt  out  NREQ  one-hot grant, registered.
- busy  out  1  high while an operation is in progress (state != IDLE).
- res  out  W+1  registered sum {cout, s}; holds its value until the next completion.
- res_id  out  IDW  id of the requester owning res.
- res_valid  out  1  single-cycle completion pulse.
- bcd_err  out  1  registered with res; 1 if latched A>9 or B>9.

Behaviour:
- Reset: resetn=0 forces the following, asynchronously:
  - state=IDLE;
  - gnt, res, res_id, res_valid, bcd_err all 0; busy=0;
  - round-robin pointer ptr=NREQ-1, so requester 0 has first priority;
  - settle counter cnt=0.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner: the first set req bit searching ptr+1, ptr+2, … modulo NREQ.
  - On the edge, latch op_a/op_b/cin slices of the winner into opA/opB/opC, set gnt=onehot(winner), ptr=winner, cnt=ADD_LAT, and go to EXEC.
- EXEC:
  - The adder operates only on the latched opA/opB/opC.
  - Each cycle cnt decrements.
  - On the edge where cnt==1:
    - res <= adder {cout,s};
    - bcd_err <= (opA>9)|(opB>9);
    - res_id <= ptr;
    - go to DONE.
- DONE:
  - res_valid=1 for exactly this cycle; gnt is still held.
  - Next edge: gnt<=0, go to IDLE.
- Latency: from the IDLE edge that grants to the res_valid cycle is ADD_LAT+1 edges. One operation completes every ADD_LAT+2 cycles.
- Handshake rules:
  - A requester must hold req and operands until it sees its gnt bit.
  - Operands are sampled only at the grant edge; later changes are ignored.
  - Dropping req during EXEC/DONE does not abort; the result is still delivered.
  - A requester wanting another operation keeps req high. It is re-granted only after all other pending requesters have been served (fairness).
- Arithmetic:
  - res = opA + opB + opC, range 0..31; no saturation, no BCD correction.
  - bcd_err is informational only; the sum is computed regardless.
- Simultaneous requests: round-robin order. No requester waits more than NREQ-1 operations.
- Reset mid-operation: the operation is aborted, no res_valid pulse, and all outputs return to reset values.
- gnt is always one-hot or zero; res_valid is never high in two consecutive cycles.

Decomposition:
- Shared package adder_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_DONE=2'd2;
  - BCD_MAX=4'd9.
- One sub-module, add4_ripple: a W-bit ripple-carry adder built from full-adder cells, with inputs a, b, ci and outputs s[W-1:0], co.
- Arbiter priority search and FSM live in adder_share_ctrl.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with req=4'b1111 → gnt=0, res=0, res_valid=0, busy=0. After release, the first grant is gnt=4'b0001.
2. Single add: req[2]=1, A2=7, B2=5, cin2=1, ADD_LAT=1 → gnt=4'b0100 after 1 edge, res_valid after 2 edges with res=5'd13, res_id=2, bcd_err=0. gnt=0 one cycle later.
3. Round-robin: req=4'b1011 held constant → grant order 0,1,3,0,1,3. res_valid pulses are spaced 3 cycles apart (ADD_LAT=1).
4. Boundary: A=15, B=15, cin=1 → res=5'd31, bcd_err=1. Also A=9, B=9, cin=0 → res=5'd18, bcd_err=0.
5. Operand change / req drop: change A and deassert req on the cycle after the grant → result uses the original operands and res_valid still pulses once.
6. Abort: assert resetn=0 during EXEC with ADD_LAT=3 → no res_valid pulse. After release, the pending requester with the lowest index ≥0 is granted first.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : State encoding and constants shared by the adder-sharing block.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DONE = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add4_ripple.sv
`default_nettype none
// ============================================================================
// Module      : add4_ripple
// Description : W-bit ripple-carry adder built from a chain of full-adder cells.
// Revision    : 1.0 - initial release
// ============================================================================
module add4_ripple #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[W];

endmodule
`default_nettype wire

// File: rtl/adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_share_ctrl
// Description : Round-robin controller sharing one ripple adder among NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_share_ctrl
  import adder_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int ADD_LAT = 1,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  input  logic [NREQ-1:0]   cin,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W:0]        res,
  output logic [IDW-1:0]    res_id,
  output logic              res_valid,
  output logic              bcd_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_win;
  logic            w_found;
  logic [2:0]      r_cnt;
  logic [W-1:0]    r_opa, r_opb, w_sel_a, w_sel_b;
  logic            r_opc, w_sel_c;
  logic [W-1:0]    w_sum;
  logic            w_co;
  logic            w_grant, w_finish, w_release;
  logic [NREQ-1:0] r_gnt;
  logic [W:0]      r_res;
  logic [IDW-1:0]  r_res_id;
  logic            r_res_valid, r_bcd_err;

  // Requester index reached by stepping 'step' places past 'base', wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int step);
    int t;
    t = (int'(base) + step) % NREQ;
    return IDW'(t);
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    w_sel_c = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_sel_a = op_a[i*W +: W];
        w_sel_b = op_b[i*W +: W];
        w_sel_c = cin[i];
      end
    end
  end

  add4_ripple #(.W(W)) u_add (
    .a  (r_opa),
    .b  (r_opb),
    .ci (r_opc),
    .s  (w_sum),
    .co (w_co)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_finish    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_grant     = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (r_cnt == 3'd1) begin
          w_finish    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_release   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_ptr       <= IDW'(NREQ - 1);
      r_cnt       <= 3'd0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_opc       <= 1'b0;
      r_gnt       <= '0;
      r_res       <= '0;
      r_res_id    <= '0;
      r_res_valid <= 1'b0;
      r_bcd_err   <= 1'b0;
    end else begin
      r_res_valid <= w_finish;
      if (w_grant) begin
        // Operands are captured only here; later input changes are ignored.
        r_opa <= w_sel_a;
        r_opb <= w_sel_b;
        r_opc <= w_sel_c;
        r_gnt <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        r_ptr <= w_win;
        r_cnt <= 3'(ADD_LAT);
      end else if (r_state == EXEC) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (w_finish) begin
        r_res     <= {w_co, w_sum};
        r_bcd_err <= (r_opa > W'(BCD_MAX)) | (r_opb > W'(BCD_MAX));
        r_res_id  <= r_ptr;
      end
      if (w_release) r_gnt <= '0;
    end
  end

  assign gnt       = r_gnt;
  assign busy      = (r_state != IDLE);
  assign res       = r_res;
  assign res_id    = r_res_id;
  assign res_valid = r_res_valid;
  assign bcd_err   = r_bcd_err;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_share_ctrl
// Description : Directed bench for adder_share_ctrl at ADD_LAT=1 and ADD_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_share_ctrl;

  logic        CLOCK_50;
  logic        r_rstn;
  logic [3:0]  r_req;
  logic [15:0] r_opa, r_opb;
  logic [3:0]  r_cin;

  logic [3:0]  w_gnt1, w_gnt3;
  logic        w_busy1, w_busy3;
  logic [4:0]  w_res1, w_res3;
  logic [1:0]  w_id1, w_id3;
  logic        w_val1, w_val3;
  logic        w_bcd1, w_bcd3;

  int n_total = 0;
  int n_bad   = 0;

  adder_share_ctrl #(.NREQ(4), .W(4), .ADD_LAT(1)) u_dut (
    .CLOCK_50 (CLOCK_50), .resetn (r_rstn), .req (r_req),
    .op_a (r_opa), .op_b (r_opb), .cin (r_cin),
    .gnt (w_gnt1), .busy (w_busy1), .res (w_res1), .res_id (w_id1),
    .res_valid (w_val1), .bcd_err (w_bcd1)
  );

  adder_share_ctrl #(.NREQ(4), .W(4), .ADD_LAT(3)) u_dut_lat3 (
    .CLOCK_50 (CLOCK_50), .resetn (r_rstn), .req (r_req),
    .op_a (r_opa), .op_b (r_opb), .cin (r_cin),
    .gnt (w_gnt3), .busy (w_busy3), .res (w_res3), .res_id (w_id3),
    .res_valid (w_val3), .bcd_err (w_bcd3)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic c);
    r_opa[i*4 +: 4] = a;
    r_opb[i*4 +: 4] = b;
    r_cin[i]        = c;
  endtask

  task automatic do_reset();
    r_rstn = 1'b0;
    tick();
    tick();
    r_rstn = 1'b1;
  endtask

  int         ord [6] = '{0, 1, 3, 0, 1, 3};
  logic [4:0] rr_exp [4] = '{5'd1, 5'd5, 5'd0, 5'd11};

  initial begin
    r_rstn = 1'b0;
    r_req  = 4'b1111;
    r_opa  = '0;
    r_opb  = '0;
    r_cin  = '0;

    // reset state with all requests pending
    repeat (3) tick();
    chk("rst_gnt",   w_gnt1,  0);
    chk("rst_res",   w_res1,  0);
    chk("rst_valid", w_val1,  0);
    chk("rst_busy",  w_busy1, 0);
    r_rstn = 1'b1;
    tick();
    chk("first_gnt",  w_gnt1,  4'b0001);
    chk("first_busy", w_busy1, 1);
    r_req = 4'b0000;
    tick();
    chk("first_valid", w_val1, 1);
    tick();
    chk("first_release", w_gnt1, 0);

    // single add on requester 2
    set_op(2, 4'd7, 4'd5, 1'b1);
    r_req = 4'b0100;
    tick();
    chk("single_gnt",    w_gnt1, 4'b0100);
    chk("single_novalid", w_val1, 0);
    r_req = 4'b0000;
    tick();
    chk("single_valid", w_val1, 1);
    chk("single_res",   w_res1, 13);
    chk("single_id",    w_id1,  2);
    chk("single_bcd",   w_bcd1, 0);
    chk("single_hold",  w_gnt1, 4'b0100);
    tick();
    chk("single_gnt0",  w_gnt1, 0);
    chk("single_pulse", w_val1, 0);
    chk("single_idle",  w_busy1, 0);
    chk("single_keep",  w_res1, 13);

    // round-robin with req=1011 held
    do_reset();
    set_op(0, 4'd1, 4'd0, 1'b0);
    set_op(1, 4'd2, 4'd2, 1'b1);
    set_op(2, 4'd3, 4'd4, 1'b0);
    set_op(3, 4'd4, 4'd6, 1'b1);
    r_req = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_gnt", w_gnt1, 32'(4'b0001 << ord[k]));
      tick();
      chk("rr_valid", w_val1, 1);
      chk("rr_id",    w_id1,  ord[k]);
      chk("rr_res",   w_res1, rr_exp[ord[k]]);
      tick();
      chk("rr_gap", w_val1, 0);
      chk("rr_rel", w_gnt1, 0);
    end
    r_req = 4'b0000;

    // operand extremes on requester 0
    set_op(0, 4'd15, 4'd15, 1'b1);
    r_req = 4'b0001;
    tick();
    chk("max_gnt", w_gnt1, 4'b0001);
    r_req = 4'b0000;
    tick();
    chk("max_res", w_res1, 31);
    chk("max_bcd", w_bcd1, 1);
    tick();
    set_op(0, 4'd9, 4'd9, 1'b0);
    r_req = 4'b0001;
    tick();
    r_req = 4'b0000;
    tick();
    chk("nine_valid", w_val1, 1);
    chk("nine_res",   w_res1, 18);
    chk("nine_bcd",   w_bcd1, 0);
    tick();

    // operands change and req drops after the grant
    set_op(1, 4'd3, 4'd4, 1'b0);
    r_req = 4'b0010;
    tick();
    chk("drop_gnt", w_gnt1, 4'b0010);
    set_op(1, 4'd12, 4'd4, 1'b1);
    r_req = 4'b0000;
    tick();
    chk("drop_valid", w_val1, 1);
    chk("drop_res",   w_res1, 7);
    chk("drop_id",    w_id1,  1);
    tick();
    chk("drop_once", w_val1, 0);
    tick();
    chk("drop_quiet", w_val1, 0);
    chk("drop_gnt0",  w_gnt1, 0);

    // ADD_LAT=3 latency, then abort mid-EXEC
    do_reset();
    set_op(2, 4'd7, 4'd5, 1'b1);
    r_req = 4'b0100;
    tick();
    chk("l3_gnt", w_gnt3, 4'b0100);
    r_req = 4'b0000;
    tick();
    chk("l3_wait1", w_val3, 0);
    tick();
    chk("l3_wait2", w_val3, 0);
    tick();
    chk("l3_valid", w_val3, 1);
    chk("l3_res",   w_res3, 13);
    chk("l3_id",    w_id3,  2);
    tick();
    chk("l3_rel", w_gnt3, 0);

    set_op(0, 4'd1, 4'd1, 1'b0);
    set_op(1, 4'd2, 4'd3, 1'b0);
    r_req = 4'b0001;
    tick();
    chk("ab_gnt", w_gnt3, 4'b0001);
    tick();
    r_rstn = 1'b0;
    #1;
    chk("ab_gnt0",  w_gnt3,  0);
    chk("ab_busy",  w_busy3, 0);
    chk("ab_res",   w_res3,  0);
    chk("ab_valid", w_val3,  0);
    r_req = 4'b0110;
    tick();
    chk("ab_hold_valid", w_val3, 0);
    tick();
    r_rstn = 1'b1;
    tick();
    chk("ab_first_gnt", w_gnt3, 4'b0010);
    chk("ab_no_valid",  w_val3, 0);
    tick();
    tick();
    tick();
    chk("ab_valid1", w_val3, 1);
    chk("ab_res1",   w_res3, 5);
    chk("ab_id1",    w_id3,  1);
    tick();
    chk("ab_rel1", w_gnt3, 0);
    tick();
    chk("ab_next_gnt", w_gnt3, 4'b0100);
    r_req = 4'b0000;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
